// File: rtl/carbon_fabric_arbiter.sv
// Round-robin arbiter that shares one fabric master port among N_REQ bring-up masters.
// One transaction is in flight at a time. A missing response produces a synthesised error response.
module carbon_fabric_arbiter #(
    parameter int N_REQ          = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int OP_W           = 8,
    parameter int SIZE_W         = 2,
    parameter int ATTR_W         = 8,
    parameter int ID_W           = 4,
    parameter int CODE_W         = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter logic [CODE_W-1:0] TIMEOUT_CODE = 4'hF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           s_req_valid,
    output logic [N_REQ-1:0]           s_req_ready,
    input  logic [N_REQ*OP_W-1:0]      s_req_op,
    input  logic [N_REQ*ADDR_W-1:0]    s_req_addr,
    input  logic [N_REQ*DATA_W-1:0]    s_req_wdata,
    input  logic [N_REQ*DATA_W/8-1:0]  s_req_wstrb,
    input  logic [N_REQ*SIZE_W-1:0]    s_req_size,
    input  logic [N_REQ*ATTR_W-1:0]    s_req_attr,
    input  logic [N_REQ*ID_W-1:0]      s_req_id,
    output logic [N_REQ-1:0]           s_rsp_valid,
    input  logic [N_REQ-1:0]           s_rsp_ready,
    output logic [DATA_W-1:0]          s_rsp_rdata,
    output logic [CODE_W-1:0]          s_rsp_code,
    output logic [ID_W-1:0]            s_rsp_id,
    output logic                       m_req_valid,
    input  logic                       m_req_ready,
    output logic [OP_W-1:0]            m_req_op,
    output logic [ADDR_W-1:0]          m_req_addr,
    output logic [DATA_W-1:0]          m_req_wdata,
    output logic [DATA_W/8-1:0]        m_req_wstrb,
    output logic [SIZE_W-1:0]          m_req_size,
    output logic [ATTR_W-1:0]          m_req_attr,
    output logic [ID_W-1:0]            m_req_id,
    input  logic                       m_rsp_valid,
    output logic                       m_rsp_ready,
    input  logic [DATA_W-1:0]          m_rsp_rdata,
    input  logic [CODE_W-1:0]          m_rsp_code,
    input  logic [ID_W-1:0]            m_rsp_id,
    output logic                       busy,
    input  logic                       stat_clr,
    output logic                       timeout_sticky,
    output logic                       stray_sticky,
    output logic [1:0]                 state_dbg
);
    // Handshake: a transfer happens on a cycle where valid and ready are both high at the rising edge.
    // A valid, once raised, should hold with a stable payload until it transfers.
    localparam int STRB_W   = DATA_W / 8;
    localparam int OW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
        $error("carbon_fabric_arbiter: N_REQ must be within 2..8");
    end
    if (N_REQ > (1 << ID_W)) begin : g_bad_idw
        $error("carbon_fabric_arbiter: owner index does not fit in ID_W");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RSP, ST_ERR} state_t;

    state_t            state;
    logic [OW-1:0]     rr_ptr;
    logic [OW-1:0]     owner;
    logic [OW-1:0]     next_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [ID_W-1:0]   saved_id;
    logic [ID_W-1:0]   sel_id;

    // The downstream ID is only the owner index. The requester's own ID is restored from saved_id.
    logic unused_m_rsp_id;
    assign unused_m_rsp_id = ^m_rsp_id;

    // Search from ptr upward with wrap-around. The loop runs in reverse so that the closest valid requester wins.
    function automatic logic [OW-1:0] rr_pick(input logic [N_REQ-1:0] v, input logic [OW-1:0] ptr);
        logic [OW-1:0] sel;
        int            idx;
        sel = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (v[idx]) sel = OW'(idx);
        end
        return sel;
    endfunction

    assign next_ptr  = (owner == OW'(N_REQ - 1)) ? '0 : owner + OW'(1);
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

    always_comb begin
        m_req_op    = s_req_op[int'(owner)*OP_W +: OP_W];
        m_req_addr  = s_req_addr[int'(owner)*ADDR_W +: ADDR_W];
        m_req_wdata = s_req_wdata[int'(owner)*DATA_W +: DATA_W];
        m_req_wstrb = s_req_wstrb[int'(owner)*STRB_W +: STRB_W];
        m_req_size  = s_req_size[int'(owner)*SIZE_W +: SIZE_W];
        m_req_attr  = s_req_attr[int'(owner)*ATTR_W +: ATTR_W];
        m_req_id    = ID_W'(owner);
        sel_id      = s_req_id[int'(owner)*ID_W +: ID_W];
        m_req_valid = 1'b0;
        s_req_ready = '0;
        s_rsp_valid = '0;
        s_rsp_rdata = m_rsp_rdata;
        s_rsp_code  = m_rsp_code;
        s_rsp_id    = saved_id;
        m_rsp_ready = 1'b1;
        case (state)
            ST_REQ: begin
                m_req_valid        = s_req_valid[owner];
                s_req_ready[owner] = m_req_ready;
            end
            ST_RSP: begin
                m_rsp_ready        = s_rsp_ready[owner];
                s_rsp_valid[owner] = m_rsp_valid;
            end
            ST_ERR: begin
                s_rsp_valid[owner] = 1'b1;
                s_rsp_rdata        = '0;
                s_rsp_code         = TIMEOUT_CODE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            rr_ptr         <= '0;
            owner          <= '0;
            cnt            <= '0;
            saved_id       <= '0;
            timeout_sticky <= 1'b0;
            stray_sticky   <= 1'b0;
        end else begin
            if (stat_clr) begin
                timeout_sticky <= 1'b0;
                stray_sticky   <= 1'b0;
            end
            // Outside ST_RSP, m_rsp_ready is high, so any response here is consumed and dropped.
            if (state != ST_RSP && m_rsp_valid) stray_sticky <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (|s_req_valid) begin
                        owner <= rr_pick(s_req_valid, rr_ptr);
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!s_req_valid[owner]) begin
                        state <= ST_IDLE;
                    end else if (m_req_ready) begin
                        saved_id <= sel_id;
                        cnt      <= '0;
                        state    <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (m_rsp_valid && s_rsp_ready[owner]) begin
                        rr_ptr <= next_ptr;
                        state  <= ST_IDLE;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        // A response that is pending at the terminal count holds off the timeout until it is accepted.
                        if (cnt == CNT_LAST) begin
                            if (!m_rsp_valid) begin
                                timeout_sticky <= 1'b1;
                                state          <= ST_ERR;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_ERR: begin
                    if (s_rsp_ready[owner]) begin
                        rr_ptr <= next_ptr;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_carbon_fabric_arbiter.sv
// Bench for carbon_fabric_arbiter: randomised transactions checked against a transaction-level
// model of round-robin ownership, plus directed timeout, stray-response and reset scenarios.
module tb_carbon_fabric_arbiter;
    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int OPW = 8;
    localparam int SW  = 2;
    localparam int ATW = 8;
    localparam int IDW = 4;
    localparam int CW  = 4;
    localparam int TO  = 8;
    localparam int BW  = DW / 8;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]     s_req_valid, s_req_ready, s_rsp_valid, s_rsp_ready;
    logic [N*OPW-1:0] s_req_op;
    logic [N*AW-1:0]  s_req_addr;
    logic [N*DW-1:0]  s_req_wdata;
    logic [N*BW-1:0]  s_req_wstrb;
    logic [N*SW-1:0]  s_req_size;
    logic [N*ATW-1:0] s_req_attr;
    logic [N*IDW-1:0] s_req_id;
    logic [DW-1:0]    s_rsp_rdata, m_rsp_rdata, m_req_wdata;
    logic [CW-1:0]    s_rsp_code, m_rsp_code;
    logic [IDW-1:0]   s_rsp_id, m_req_id, m_rsp_id;
    logic             m_req_valid, m_req_ready, m_rsp_valid, m_rsp_ready;
    logic [OPW-1:0]   m_req_op;
    logic [AW-1:0]    m_req_addr;
    logic [BW-1:0]    m_req_wstrb;
    logic [SW-1:0]    m_req_size;
    logic [ATW-1:0]   m_req_attr;
    logic             busy, stat_clr, timeout_sticky, stray_sticky;
    logic [1:0]       state_dbg;

    logic [OPW-1:0] p_op[N];
    logic [AW-1:0]  p_addr[N];
    logic [DW-1:0]  p_wdata[N];
    logic [BW-1:0]  p_wstrb[N];
    logic [SW-1:0]  p_size[N];
    logic [ATW-1:0] p_attr[N];
    logic [IDW-1:0] p_id[N];

    int n_checks = 0;
    int n_err    = 0;
    int mdl_rr;
    bit mdl_to, mdl_stray;
    logic [IDW-1:0] exp_q[$];

    carbon_fabric_arbiter #(
        .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .OP_W(OPW), .SIZE_W(SW), .ATTR_W(ATW),
        .ID_W(IDW), .CODE_W(CW), .TIMEOUT_CYCLES(TO), .TIMEOUT_CODE(4'hF)
    ) dut (
        .clk(clk), .rst(rst),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .s_req_op(s_req_op), .s_req_addr(s_req_addr), .s_req_wdata(s_req_wdata),
        .s_req_wstrb(s_req_wstrb), .s_req_size(s_req_size), .s_req_attr(s_req_attr),
        .s_req_id(s_req_id),
        .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready),
        .s_rsp_rdata(s_rsp_rdata), .s_rsp_code(s_rsp_code), .s_rsp_id(s_rsp_id),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_req_op(m_req_op), .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata),
        .m_req_wstrb(m_req_wstrb), .m_req_size(m_req_size), .m_req_attr(m_req_attr),
        .m_req_id(m_req_id),
        .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
        .m_rsp_rdata(m_rsp_rdata), .m_rsp_code(m_rsp_code), .m_rsp_id(m_rsp_id),
        .busy(busy), .stat_clr(stat_clr),
        .timeout_sticky(timeout_sticky), .stray_sticky(stray_sticky),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            s_req_op[i*OPW +: OPW]   = p_op[i];
            s_req_addr[i*AW +: AW]   = p_addr[i];
            s_req_wdata[i*DW +: DW]  = p_wdata[i];
            s_req_wstrb[i*BW +: BW]  = p_wstrb[i];
            s_req_size[i*SW +: SW]   = p_size[i];
            s_req_attr[i*ATW +: ATW] = p_attr[i];
            s_req_id[i*IDW +: IDW]   = p_id[i];
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        return N'(1) << i;
    endfunction

    // Reference arbitration: first requester in the mask at or after the round-robin pointer.
    function automatic int pick(input logic [N-1:0] mask);
        for (int k = 0; k < N; k++) begin
            if (mask[(mdl_rr + k) % N]) return (mdl_rr + k) % N;
        end
        return mdl_rr;
    endfunction

    task automatic rand_payload();
        for (int i = 0; i < N; i++) begin
            p_op[i]    = OPW'($urandom);
            p_addr[i]  = $urandom;
            p_wdata[i] = $urandom;
            p_wstrb[i] = BW'($urandom);
            p_size[i]  = SW'($urandom);
            p_attr[i]  = ATW'($urandom);
            p_id[i]    = IDW'($urandom);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_req_valid = '0; m_req_ready = 1'b0; m_rsp_valid = 1'b0; s_rsp_ready = '0;
        m_rsp_rdata = '0; m_rsp_code = '0; m_rsp_id = '0; stat_clr = 1'b0;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_m_req_valid", m_req_valid, 0);
        chk("rst_s_req_ready", s_req_ready, 0);
        chk("rst_s_rsp_valid", s_rsp_valid, 0);
        chk("rst_stickies", {timeout_sticky, stray_sticky}, 0);
        rst = 1'b0;
        mdl_rr = 0; mdl_to = 0; mdl_stray = 0;
    endtask

    // One complete transaction, called from IDLE: request stall, response delay, then requester response stall.
    task automatic do_txn(input logic [N-1:0] mask, input int rdy_dly, input int rsp_dly, input int srdy_dly);
        int             own;
        logic [IDW-1:0] sid;
        logic [DW-1:0]  rd;
        logic [CW-1:0]  rc;
        logic [N-1:0]   oth;
        own = pick(mask);
        sid = p_id[own];
        s_req_valid = mask;
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_m_req_valid", m_req_valid, 0);
        chk("idle_s_req_ready", s_req_ready, 0);
        step();
        for (int k = 0; k <= rdy_dly; k++) begin
            m_req_ready = (k == rdy_dly);
            #1;
            chk("req_valid", m_req_valid, 1);
            chk("req_id", m_req_id, own);
            chk("req_payload", {m_req_op, m_req_addr, m_req_wdata, m_req_wstrb, m_req_size, m_req_attr},
                {p_op[own], p_addr[own], p_wdata[own], p_wstrb[own], p_size[own], p_attr[own]});
            chk("req_s_ready", s_req_ready, (k == rdy_dly) ? onehot(own) : '0);
            chk("req_s_rsp_valid", s_rsp_valid, 0);
            step();
        end
        s_req_valid = '0;
        m_req_ready = 1'b0;
        for (int k = 0; k < rsp_dly; k++) begin
            #1;
            chk("wait_s_rsp_valid", s_rsp_valid, 0);
            chk("wait_busy", busy, 1);
            step();
        end
        rd = $urandom;
        rc = CW'($urandom);
        m_rsp_valid = 1'b1; m_rsp_rdata = rd; m_rsp_code = rc; m_rsp_id = IDW'($urandom);
        for (int k = 0; k <= srdy_dly; k++) begin
            oth = N'($urandom) & ~onehot(own);
            s_rsp_ready = oth | ((k == srdy_dly) ? onehot(own) : '0);
            #1;
            chk("rsp_valid", s_rsp_valid, onehot(own));
            chk("rsp_payload", {s_rsp_rdata, s_rsp_code, s_rsp_id}, {rd, rc, sid});
            chk("rsp_m_ready", m_rsp_ready, k == srdy_dly);
            chk("rsp_s_req_ready", s_req_ready, 0);
            step();
        end
        m_rsp_valid = 1'b0;
        s_rsp_ready = '0;
        mdl_rr = (own + 1) % N;
        #1;
        chk("done_busy", busy, 0);
        chk("done_s_rsp_valid", s_rsp_valid, 0);
        chk("done_stickies", {timeout_sticky, stray_sticky}, {mdl_to, mdl_stray});
    endtask

    task automatic test_timeout();
        int             own;
        logic [IDW-1:0] sid;
        logic [N-1:0]   mask;
        mask = N'($urandom_range(1, (1 << N) - 1));
        own  = pick(mask);
        sid  = p_id[own];
        s_req_valid = mask;
        step();
        m_req_ready = 1'b1;
        step();
        m_req_ready = 1'b0;
        s_req_valid = '0;
        for (int k = 0; k < TO; k++) begin
            #1;
            chk("to_wait_s_rsp_valid", s_rsp_valid, 0);
            chk("to_wait_sticky", timeout_sticky, 0);
            step();
        end
        mdl_to = 1;
        chk("to_s_rsp_valid", s_rsp_valid, onehot(own));
        chk("to_payload", {s_rsp_rdata, s_rsp_code, s_rsp_id}, {32'h0, 4'hF, sid});
        chk("to_sticky", timeout_sticky, 1);
        chk("to_busy", busy, 1);
        s_rsp_ready = onehot(own);
        step();
        s_rsp_ready = '0;
        mdl_rr = (own + 1) % N;
        chk("to_done_busy", busy, 0);
        chk("to_done_s_rsp_valid", s_rsp_valid, 0);
        step();
        step();
        m_rsp_valid = 1'b1;
        #1;
        chk("late_m_rsp_ready", m_rsp_ready, 1);
        chk("late_s_rsp_valid", s_rsp_valid, 0);
        step();
        m_rsp_valid = 1'b0;
        mdl_stray = 1;
        chk("late_stickies", {timeout_sticky, stray_sticky}, {mdl_to, mdl_stray});
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        mdl_to = 0; mdl_stray = 0;
        chk("clr_stickies", {timeout_sticky, stray_sticky}, 0);
        stat_clr = 1'b1;
        m_rsp_valid = 1'b1;
        step();
        stat_clr = 1'b0;
        m_rsp_valid = 1'b0;
        mdl_stray = 1;
        chk("set_over_clr", {timeout_sticky, stray_sticky}, {mdl_to, mdl_stray});
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        mdl_stray = 0;
        chk("clr_again", {timeout_sticky, stray_sticky}, 0);
    endtask

    // All requesters valid and a slave that always answers: each transaction takes three cycles.
    task automatic test_fairness();
        int             nf;
        logic [IDW-1:0] e;
        do_reset();
        for (int r = 0; r < 6; r++) exp_q.push_back(IDW'(r % N));
        s_req_valid = '1; m_req_ready = 1'b1; m_rsp_valid = 1'b1; s_rsp_ready = '1;
        nf = 0;
        for (int c = 0; c < 18; c++) begin
            #1;
            chk("fair_fire_slot", m_req_valid, c % 3 == 1);
            if (m_req_valid && m_req_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("fair_grant", m_req_id, e);
                chk("fair_s_ready", s_req_ready, onehot(int'(e)));
                nf++;
            end
            if (c % 3 == 2) chk("fair_rsp", s_rsp_valid, onehot((c / 3) % N));
            step();
        end
        s_req_valid = '0; m_req_ready = 1'b0; m_rsp_valid = 1'b0; s_rsp_ready = '0;
        mdl_rr = 6 % N;
        mdl_stray = 1;
        chk("fair_fires", nf, 6);
        chk("fair_queue_empty", exp_q.size(), 0);
        #1;
        chk("fair_stray", stray_sticky, mdl_stray);
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        mdl_stray = 0;
    endtask

    task automatic test_reset_in_rsp();
        logic [N-1:0] mask;
        mask = N'($urandom_range(1, (1 << N) - 1));
        s_req_valid = mask;
        step();
        m_req_ready = 1'b1;
        step();
        m_req_ready = 1'b0;
        s_req_valid = '0;
        step();
        rst = 1'b1;
        step();
        chk("rsprst_busy", busy, 0);
        chk("rsprst_valids", {m_req_valid, s_rsp_valid, s_req_ready}, 0);
        rst = 1'b0;
        mdl_rr = 0; mdl_to = 0; mdl_stray = 0;
        m_rsp_valid = 1'b1;
        #1;
        chk("rsprst_m_rsp_ready", m_rsp_ready, 1);
        chk("rsprst_s_rsp_valid", s_rsp_valid, 0);
        step();
        m_rsp_valid = 1'b0;
        mdl_stray = 1;
        chk("rsprst_stray", {timeout_sticky, stray_sticky}, {mdl_to, mdl_stray});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        rand_payload();
        do_reset();

        p_addr[1]  = 32'h1000_0004;
        p_wdata[1] = 32'h1234_5678;
        p_id[1]    = 4'd3;
        do_txn(4'b0010, 0, 1, 0);

        for (int t = 0; t < 24; t++) begin
            rand_payload();
            do_txn(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 3),
                   $urandom_range(0, 4), $urandom_range(0, 3));
        end

        rand_payload();
        do_txn(N'($urandom_range(1, (1 << N) - 1)), 5, 0, 4);
        rand_payload();
        do_txn(N'($urandom_range(1, (1 << N) - 1)), 0, TO - 1, 0);

        rand_payload();
        test_timeout();
        test_fairness();
        rand_payload();
        test_reset_in_rsp();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
